// File: rtl/memory_arb_pkg.sv
// Shared types and defaults for memory_arbiter and its round-robin picker.
package memory_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

    localparam int unsigned DefAddrWidth = 8;
    localparam int unsigned DefDataWidth = 31;

    typedef struct packed {
        logic                    wr;
        logic [DefAddrWidth-1:0] addr;
        logic [DefDataWidth-1:0] wdata;
    } mem_req_t;

    // Index width for an n-entry one-hot; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr_i+1 with wrap.
module rr_arbiter
    import memory_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IdxW = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        // Offset 1..NUM_REQ so the last winner is considered last.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IdxW'((32'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin sharer of one single-port memory slave, one transaction in flight.
// Optional response watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module memory_arbiter
    import memory_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          mem_req,
    output logic                          wr,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH-1:0]         rdata,
    input  logic                          slv_rsp,
    output logic                          busy
);

    localparam int unsigned IdxW = idx_width(NUM_REQ);

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } lat_req_t;

    arb_state_e           state_q, state_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   owner_q, owner_d;
    lat_req_t             req_q, req_d;
    lat_req_t             sel_req;
    logic                 mem_req_q, mem_req_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   gnt;
    logic [IdxW-1:0]      gnt_idx;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rsp_err_q, rsp_err_d;
    assign rsp_err = rsp_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign rsp_err        = 1'b0;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    always_comb begin
        sel_req = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_req.wr    = req_wr[i];
                sel_req.addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_req.wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        req_d       = req_q;
        mem_req_d   = 1'b0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    state_d   = StIssue;
                    ptr_d     = gnt_idx;
                    owner_d   = gnt;
                    req_d     = sel_req;
                    mem_req_d = 1'b1;
                end
            end
            StIssue: begin
                state_d = StWait;
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StWait: begin
                // wr drops on leaving WAIT; addr/wdata are left as they were.
                if (slv_rsp) begin
                    state_d     = StResp;
                    rsp_valid_d = owner_q;
                    rsp_rdata_d = rdata;
                    req_d.wr    = 1'b0;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT)) begin
                    state_d     = StResp;
                    rsp_valid_d = owner_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    req_d.wr    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= IdxW'(NUM_REQ - 1);
            owner_q     <= '0;
            req_q       <= '0;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            req_q       <= req_d;
            mem_req_q   <= mem_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Grant is combinational in IDLE and suppressed while reset is held.
    assign req_ready = (state_q == StIdle && !reset) ? gnt : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_req   = mem_req_q;
    assign wr        = req_q.wr;
    assign addr      = req_q.addr;
    assign wdata     = req_q.wdata;
    assign busy      = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (two requesters, TIMEOUT=8).
module tb_memory_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr;
    logic [15:0] req_addr;
    logic [61:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [30:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        wr;
    logic [7:0]  addr;
    logic [30:0] wdata;
    logic [30:0] rdata;
    logic        slv_rsp;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    logic [1:0] exp_gnt  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0] exp_addr [4] = '{8'h11, 8'h22, 8'h11, 8'h22};

    memory_arbiter #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (31),
        .NUM_REQ    (2),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_req   (mem_req),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .slv_rsp   (slv_rsp),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rdata     = '0;
        slv_rsp   = 1'b0;
        tick();
        tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wr", wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_addr", addr, 0);
        chk("rst_rdata", rsp_rdata, 0);
        #3 reset = 1'b0;
        tick();

        // Requester 0 write, slv_rsp two cycles after mem_req.
        req_valid = 2'b01;
        req_wr    = 2'b01;
        req_addr  = {8'h00, 8'h05};
        req_wdata = {31'h0, 31'h1234};
        #1;
        chk("w_ready", req_ready, 2'b01);
        chk("w_idle_busy", busy, 0);
        tick();
        req_valid = '0;
        chk("w_mem_req", mem_req, 1);
        chk("w_wr", wr, 1);
        chk("w_addr", addr, 8'h05);
        chk("w_wdata", wdata, 31'h1234);
        chk("w_ready_issue", req_ready, 0);
        tick();
        chk("w_mem_req_wait", mem_req, 0);
        chk("w_wr_wait", wr, 1);
        tick();
        slv_rsp = 1'b1;
        rdata   = 31'h7fff0000;
        chk("w_no_rsp_yet", rsp_valid, 0);
        tick();
        slv_rsp = 1'b0;
        chk("w_rsp_valid", rsp_valid, 2'b01);
        chk("w_rsp_err", rsp_err, 0);
        chk("w_wr_resp", wr, 0);
        chk("w_busy_resp", busy, 1);
        tick();
        chk("w_rsp_clear", rsp_valid, 0);
        chk("w_busy_idle", busy, 0);

        // Requester 1 read of the same address, k=1.
        req_valid = 2'b10;
        req_wr    = 2'b00;
        req_addr  = {8'h05, 8'h00};
        #1;
        chk("r_ready", req_ready, 2'b10);
        tick();
        req_valid = '0;
        chk("r_mem_req", mem_req, 1);
        chk("r_wr", wr, 0);
        chk("r_addr", addr, 8'h05);
        tick();
        slv_rsp = 1'b1;
        rdata   = 31'h1234;
        tick();
        slv_rsp = 1'b0;
        chk("r_rsp_valid", rsp_valid, 2'b10);
        chk("r_rsp_rdata", rsp_rdata, 31'h1234);
        chk("r_rsp_err", rsp_err, 0);
        tick();

        // Both requesters held valid: alternate 0,1,0,1.
        req_valid = 2'b11;
        req_addr  = {8'h22, 8'h11};
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("rr_ready", req_ready, exp_gnt[n]);
            chk("rr_idle_busy", busy, 0);
            tick();
            chk("rr_addr", addr, exp_addr[n]);
            chk("rr_issue_busy", busy, 1);
            chk("rr_issue_ready", req_ready, 0);
            tick();
            slv_rsp = 1'b1;
            chk("rr_wait_busy", busy, 1);
            tick();
            slv_rsp = 1'b0;
            chk("rr_rsp_valid", rsp_valid, exp_gnt[n]);
            chk("rr_resp_busy", busy, 1);
            tick();
        end
        req_valid = '0;

        // Requester 0 alone moves the pointer to 0, then reset hits in WAIT.
        req_valid = 2'b01;
        req_addr  = {8'h00, 8'h33};
        #1;
        chk("rw_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        tick();
        chk("rw_wait_busy", busy, 1);
        #2;
        reset     = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_mem_req", mem_req, 0);
        chk("rw_wr", wr, 0);
        chk("rw_rsp_valid", rsp_valid, 0);
        chk("rw_ready", req_ready, 0);
        chk("rw_addr", addr, 0);
        tick();
        #3;
        reset     = 1'b0;
        req_valid = '0;
        slv_rsp   = 1'b1;
        tick();
        chk("ig_idle_rsp", rsp_valid, 0);
        chk("ig_idle_busy", busy, 0);
        slv_rsp   = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("rw_next_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        slv_rsp   = 1'b1;
        chk("ig_mem_req", mem_req, 1);
        tick();
        slv_rsp = 1'b0;
        chk("ig_issue_rsp", rsp_valid, 0);
        chk("ig_issue_busy", busy, 1);
        tick();
        chk("ig_wait_rsp", rsp_valid, 0);
        chk("ig_wait_busy", busy, 1);
        slv_rsp = 1'b1;
        rdata   = 31'h4abcdef0;
        tick();
        slv_rsp = 1'b0;
        chk("ig_rsp_valid", rsp_valid, 2'b01);
        chk("ig_rsp_rdata", rsp_rdata, 31'h4abcdef0);
        chk("ig_rsp_err", rsp_err, 0);
        tick();
        chk("ig_busy_idle", busy, 0);

        // Requester 1 read with no slv_rsp for a long time.
        req_valid = 2'b10;
        req_addr  = {8'h44, 8'h00};
        #1;
        chk("to_ready", req_ready, 2'b10);
        tick();
        req_valid = '0;
        tick();
        for (int i = 0; i < 9; i++) begin
            chk("to_wait_rsp", rsp_valid, 0);
            tick();
        end
`ifdef MEM_ARB_TIMEOUT_EN
        chk("to_rsp_valid", rsp_valid, 2'b10);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        tick();
        chk("to_busy_idle", busy, 0);
        chk("to_err_clear", rsp_err, 0);
        req_valid = 2'b01;
        #1;
        chk("to_next_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        tick();
        slv_rsp = 1'b1;
        rdata   = 31'h55;
        tick();
        slv_rsp = 1'b0;
        chk("to_next_rsp", rsp_valid, 2'b01);
        chk("to_next_err", rsp_err, 0);
        chk("to_next_rdata", rsp_rdata, 31'h55);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("nt_still_wait", rsp_valid, 0);
        chk("nt_busy", busy, 1);
        chk("nt_addr_held", addr, 8'h44);
        slv_rsp = 1'b1;
        rdata   = 31'h55;
        tick();
        slv_rsp = 1'b0;
        chk("nt_rsp_valid", rsp_valid, 2'b10);
        chk("nt_rsp_err", rsp_err, 0);
        chk("nt_rsp_rdata", rsp_rdata, 31'h55);
`endif
        tick();
        chk("end_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
